// File: rtl/step_button_conditioner.sv
// Pushbutton conditioner: synchroniser, debounce FSM, single-cycle step pulse and press counter.
// Define STEP_AUTOREPEAT_EN to add auto-repeat pulses while the button stays held.
module step_button_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_PERIOD   = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       step_pulse,
  output logic       btn_level,
  output logic [7:0] press_count
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DbW-1:0]         db_cnt_q, db_cnt_d;
  logic                   step_pulse_q, step_pulse_d;
  logic                   btn_level_q, btn_level_d;
  logic [7:0]             press_count_q, press_count_d;
  logic                   s;
  logic                   rpt_fire;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
  assign s      = sync_q[SYNC_STAGES-1];

`ifdef STEP_AUTOREPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = (RptMax > 1) ? $clog2(RptMax) : 1;
  localparam logic [RptW-1:0] RptDelayLast  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RptPeriodLast = RptW'(REPEAT_PERIOD - 1);

  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic            rpt_first_q, rpt_first_d;

  // Counter is 0 in the first HELD cycle; the first interval uses the delay, later ones the period.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_fire    = 1'b0;
    if (state_q == StHeld) begin
      if (rpt_cnt_q == (rpt_first_q ? RptDelayLast : RptPeriodLast)) begin
        rpt_fire    = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RptW'(1);
      end
    end else begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    step_pulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s) begin
          state_d  = StPressWait;
          db_cnt_d = '0;
        end
      end
      StPressWait: begin
        if (!s) begin
          state_d = StIdle;
        end else if (db_cnt_q == DbLast) begin
          state_d      = StHeld;
          step_pulse_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DbW'(1);
        end
      end
      StHeld: begin
        // A release seen in the same cycle as repeat expiry suppresses the repeat pulse.
        if (!s) begin
          state_d  = StReleaseWait;
          db_cnt_d = '0;
        end else if (rpt_fire) begin
          step_pulse_d = 1'b1;
        end
      end
      StReleaseWait: begin
        if (s) begin
          state_d = StHeld;
        end else if (db_cnt_q == DbLast) begin
          state_d = StIdle;
        end else begin
          db_cnt_d = db_cnt_q + DbW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    btn_level_d   = (state_d == StHeld) || (state_d == StReleaseWait);
    press_count_d = press_count_q + {7'd0, step_pulse_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      state_q       <= StIdle;
      db_cnt_q      <= '0;
      step_pulse_q  <= 1'b0;
      btn_level_q   <= 1'b0;
      press_count_q <= '0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      step_pulse_q  <= step_pulse_d;
      btn_level_q   <= btn_level_d;
      press_count_q <= press_count_d;
    end
  end

  assign step_pulse  = step_pulse_q;
  assign btn_level   = btn_level_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_step_button_conditioner.sv
// Directed bench for step_button_conditioner; expectations hold with or without STEP_AUTOREPEAT_EN.
// Cycle k is the interval after clock edge k-1, where edge 0 is the first edge sampling the stimulus.
module tb_step_button_conditioner;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned DebCycles  = 4;
  localparam int unsigned RptDelay   = 10;
  localparam int unsigned RptPeriod  = 5;

`ifdef STEP_AUTOREPEAT_EN
  localparam int T2Hold = 12;
`else
  localparam int T2Hold = 20;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b0;
  logic       step_pulse;
  logic       btn_level;
  logic [7:0] press_count;

  int n_cmp = 0;
  int n_err = 0;
  int n_consec = 0;
  int ecnt;
  int pulse_q[$];
  int exp_q[$];
  int lvl_rise;
  int lvl_fall;
  bit lvl_dropped;
  bit prev_pulse = 1'b0;
  bit prev_lvl = 1'b0;

  step_button_conditioner #(
    .SYNC_STAGES    (SyncStages),
    .DEBOUNCE_CYCLES(DebCycles),
    .REPEAT_DELAY   (RptDelay),
    .REPEAT_PERIOD  (RptPeriod)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .step_pulse (step_pulse),
    .btn_level  (btn_level),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
    if (step_pulse === 1'b1) begin
      pulse_q.push_back(ecnt + 1);
      if (prev_pulse) n_consec++;
    end
    prev_pulse = (step_pulse === 1'b1);
    if (btn_level === 1'b1 && !prev_lvl) lvl_rise = ecnt + 1;
    if (btn_level !== 1'b1 && prev_lvl) lvl_fall = ecnt + 1;
    if (btn_level !== 1'b1) lvl_dropped = 1'b1;
    prev_lvl = (btn_level === 1'b1);
  endtask

  task automatic clear_log();
    ecnt = -1;
    pulse_q.delete();
    lvl_rise = -1;
    lvl_fall = -1;
    lvl_dropped = 1'b0;
  endtask

  task automatic apply(input logic b, input int n);
    btn_raw = b;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_raw = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  function automatic int first_pulse();
    return (pulse_q.size() > 0) ? pulse_q[0] : -1;
  endfunction

  initial begin
    clear_log();

    // 1: reset holds all outputs low even with the button pressed
    rst = 1'b1;
    btn_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("t1_reset_outs_%0d", i), int'({step_pulse, btn_level, press_count}), 0);
    end
    rst = 1'b0;
    clear_log();
    apply(1'b1, 12);
    check_eq("t1_first_pulse_cycle", first_pulse(), 7);
    check_eq("t1_pulse_count", pulse_q.size(), 1);
    check_eq("t1_press_count", int'(press_count), 1);

    // 2: clean press and release
    do_reset();
    clear_log();
    apply(1'b1, T2Hold);
    check_eq("t2_pulse_cycle", first_pulse(), 7);
    check_eq("t2_pulse_count", pulse_q.size(), 1);
    check_eq("t2_level_rise", lvl_rise, 7);
    check_eq("t2_press_count", int'(press_count), 1);
    clear_log();
    apply(1'b0, 12);
    check_eq("t2_level_fall", lvl_fall, 7);
    check_eq("t2_release_pulses", pulse_q.size(), 0);

    // 3: bounce during press restarts debounce
    do_reset();
    clear_log();
    apply(1'b1, 3);
    apply(1'b0, 1);
    apply(1'b1, 12);
    check_eq("t3_pulse_cycle", first_pulse(), 11);
    check_eq("t3_pulse_count", pulse_q.size(), 1);
    check_eq("t3_press_count", int'(press_count), 1);

    // 4: short release glitch while held
    lvl_dropped = 1'b0;
    apply(1'b0, 2);
    apply(1'b1, 8);
    check_eq("t4_level_held", int'(lvl_dropped), 0);
    check_eq("t4_pulse_count", pulse_q.size(), 1);
    check_eq("t4_press_count", int'(press_count), 1);

    // 5: long hold, HELD spans cycles 7..46
    do_reset();
    clear_log();
    apply(1'b1, 44);
    apply(1'b0, 10);
`ifdef STEP_AUTOREPEAT_EN
    exp_q = '{7, 17, 22, 27, 32, 37, 42};
`else
    exp_q = '{7};
`endif
    check_eq("t5_pulse_count", pulse_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("t5_pulse_%0d", i), (i < pulse_q.size()) ? pulse_q[i] : -1, exp_q[i]);
    end
    check_eq("t5_press_count", int'(press_count), exp_q.size());

    // 6a: reset in PRESS_WAIT with cnt=2
    do_reset();
    clear_log();
    apply(1'b1, 5);
    rst = 1'b1;
    tick();
    check_eq("t6_reset_outs", int'({step_pulse, btn_level, press_count}), 0);
    rst = 1'b0;
    apply(1'b0, 6);
    check_eq("t6_no_pulse", pulse_q.size(), 0);
    clear_log();
    apply(1'b1, 10);
    check_eq("t6_fresh_latency", first_pulse(), 7);
    apply(1'b0, 10);

    // 6b: press counter wraps on the 256th pulse
    do_reset();
    clear_log();
    for (int i = 0; i < 255; i++) begin
      apply(1'b1, 8);
      apply(1'b0, 8);
    end
    check_eq("t6_count_255", int'(press_count), 255);
    apply(1'b1, 8);
    apply(1'b0, 8);
    check_eq("t6_count_wrap", int'(press_count), 0);
    check_eq("t6_wrap_pulses", pulse_q.size(), 256);

    check_eq("no_back_to_back", n_consec, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
